// File: rtl/inv_shift_sub_stage.sv
// Decryption-round stage: InvShiftRows routing followed by 16 registered inverse-S-box
// lookups, wrapped in a 2-stage valid/ready pipeline with a global stall and a sideband tag.

module inv_sbox_rom (
    input  logic       CLK,
    input  logic       Read_Enable,
    input  logic [7:0] Read_Address,
    output logic [7:0] Read_Data
);
    // FIPS-197 InvSbox, entry a at bits [8a +: 8]
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // NOTE: the lookup register has no reset; whatever it holds is qualified by the stage valid bit.
    always_ff @(posedge CLK) begin
        if (Read_Enable) begin
            Read_Data <= INV_SBOX[{Read_Address, 3'b000} +: 8];
        end
    end
endmodule

module inv_shift_sub_stage #(
    parameter int TAG_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [0:127]     IN,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [0:127]     OUT,
    output logic [TAG_W-1:0] OUT_TAG
);
    logic             en;
    logic [0:127]     shifted;
    logic [0:127]     rom_q;
    logic             v1;
    logic [TAG_W-1:0] tag1;

    // Whole pipe moves together: it advances whenever the output slot is empty or being drained.
    assign en       = ~OUT_VALID | OUT_READY;
    assign IN_READY = en;

    for (genvar k = 0; k < 16; k++) begin : g_byte
        localparam int COL = k / 4;
        localparam int ROW = k % 4;
        localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;

        assign shifted[8*k +: 8] = IN[8*SRC +: 8];

        inv_sbox_rom u_rom (
            .CLK          (CLK),
            .Read_Enable  (en),
            .Read_Address (shifted[8*k +: 8]),
            .Read_Data    (rom_q[8*k +: 8])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            v1 <= 1'b0;
        end else if (en) begin
            v1 <= IN_VALID;
        end
    end

    always_ff @(posedge CLK) begin
        if (en) begin
            tag1 <= IN_TAG;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            OUT_VALID <= 1'b0;
            OUT       <= '0;
            OUT_TAG   <= '0;
        end else if (en) begin
            OUT_VALID <= v1;
            OUT       <= rom_q;
            OUT_TAG   <= tag1;
        end
    end
endmodule

// File: tb/tb_inv_shift_sub_stage.sv
// Bench for inv_shift_sub_stage: fixed vectors, latency/backpressure/reset sequences, and a
// negedge monitor that scores every delivered block against an algebraically derived model.

module tb_inv_shift_sub_stage;
    localparam int TAG_W = 4;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             IN_VALID;
    logic             IN_READY;
    logic [0:127]     IN;
    logic [TAG_W-1:0] IN_TAG;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [0:127]     OUT;
    logic [TAG_W-1:0] OUT_TAG;

    inv_shift_sub_stage #(.TAG_W(TAG_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN        (IN),
        .IN_TAG    (IN_TAG),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT       (OUT),
        .OUT_TAG   (OUT_TAG)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;
    int n_out = 0;
    int run_len = 0;
    int run_max = 0;

    typedef struct {
        logic [0:127]     data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        logic [0:127]     in;
        logic [TAG_W-1:0] tag;
        logic [0:127]     exp;
    } vec_t;

    exp_t       q[$];
    logic [7:0] isb [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference S-box built from GF(2^8) inversion and the affine map, then inverted.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    task automatic build_isb();
        logic [7:0] inv;
        logic [7:0] s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            isb[s] = 8'(a);
        end
    endtask

    // State as a 4x4 matrix st[row][col]; row r is rotated right by r columns.
    function automatic logic [0:127] ref_model(input logic [0:127] d);
        logic [7:0]   st [4][4];
        logic [0:127] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = d[8*(4*c+r) +: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = isb[st[r][(c - r + 4) % 4]];
        return o;
    endfunction

    function automatic logic [0:127] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: outputs are sampled on the falling edge, inputs only change just after rising edges.
    logic             stalled = 1'b0;
    logic [0:127]     prev_out;
    logic [TAG_W-1:0] prev_tag;

    always @(negedge CLK) begin
        exp_t e;
        if (!RST_N) begin
            q.delete();
            stalled = 1'b0;
            run_len = 0;
        end else begin
            check("in_ready_rule", 128'(IN_READY), 128'(!OUT_VALID || OUT_READY));
            if (stalled) begin
                check("stall_valid", 128'(OUT_VALID), 128'(1));
                check("stall_data", OUT, prev_out);
                check("stall_tag", 128'(OUT_TAG), 128'(prev_tag));
            end
            if (OUT_VALID && OUT_READY) begin
                n_out++;
                if (q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %h tag %h expected no block", OUT, OUT_TAG);
                end else begin
                    e = q.pop_front();
                    check("out_data", OUT, e.data);
                    check("out_tag", 128'(OUT_TAG), 128'(e.tag));
                end
            end
            if (IN_VALID && IN_READY) begin
                e.data = ref_model(IN);
                e.tag  = IN_TAG;
                q.push_back(e);
            end
            stalled  = OUT_VALID && !OUT_READY;
            prev_out = OUT;
            prev_tag = OUT_TAG;
            run_len  = OUT_VALID ? run_len + 1 : 0;
            if (run_len > run_max) run_max = run_len;
        end
    end

    task automatic drive_point();
        @(posedge CLK);
        #1;
    endtask

    // Presents one block from a drive point; returns just after the edge that accepted it.
    task automatic send_block(input logic [0:127] d, input logic [TAG_W-1:0] t, output int waited);
        waited   = 0;
        IN       = d;
        IN_TAG   = t;
        IN_VALID = 1'b1;
        @(negedge CLK);
        while (!IN_READY && waited < 100) begin
            waited++;
            @(negedge CLK);
        end
        if (!IN_READY) timeout("send_accept");
        drive_point();
        IN_VALID = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int cyc;
        cyc = 0;
        @(negedge CLK);
        while (!OUT_VALID && cyc < 50) begin
            cyc++;
            @(negedge CLK);
        end
        if (!OUT_VALID) timeout(name);
    endtask

    task automatic wait_outputs(input int base, input int count, input string name);
        int cyc;
        cyc = 0;
        while ((n_out - base) < count && cyc < 300) begin
            cyc++;
            @(negedge CLK);
        end
        if ((n_out - base) < count) timeout(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vecs [10];
        logic [0:127] d;
        int           waited;
        int           base;
        bit           done;

        build_isb();
        vecs[0] = '{128'h0, 4'h3, {16{8'h52}}};
        vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f, 4'h5,
                    128'h52f3a3383009d79ebf366afb8140a5d5};
        vecs[2] = '{{16{8'hff}}, 4'hf, {16{8'h7d}}};
        vecs[3] = '{{16{8'h63}}, 4'h0, 128'h0};
        vecs[4] = '{{16{8'h7c}}, 4'ha, {16{8'h01}}};
        for (int i = 5; i < 10; i++) begin
            d = rand_block();
            vecs[i] = '{d, 4'(i), ref_model(d)};
        end

        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        IN        = '0;
        IN_TAG    = '0;
        OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(negedge CLK);
        check("rst_out_valid", 128'(OUT_VALID), 128'(0));
        check("rst_out", OUT, 128'h0);
        check("rst_out_tag", 128'(OUT_TAG), 128'(0));
        check("rst_in_ready", 128'(IN_READY), 128'(1));

        // Idle with downstream stalled: random IN without IN_VALID must produce nothing.
        for (int i = 0; i < 10; i++) begin
            drive_point();
            IN     = rand_block();
            IN_TAG = 4'($urandom);
            @(negedge CLK);
            check("idle_out_valid", 128'(OUT_VALID), 128'(0));
            check("idle_in_ready", 128'(IN_READY), 128'(1));
        end

        // Exact two-cycle latency of a single block.
        drive_point();
        OUT_READY = 1'b1;
        IN        = 128'h0;
        IN_TAG    = 4'h3;
        IN_VALID  = 1'b1;
        drive_point();
        IN_VALID = 1'b0;
        @(negedge CLK);
        check("lat_cycle1_valid", 128'(OUT_VALID), 128'(0));
        @(negedge CLK);
        check("lat_cycle2_valid", 128'(OUT_VALID), 128'(1));
        check("lat_cycle2_data", OUT, {16{8'h52}});
        check("lat_cycle2_tag", 128'(OUT_TAG), 128'(3));
        @(negedge CLK);
        check("lat_cycle3_valid", 128'(OUT_VALID), 128'(0));

        // Fixed and random table vectors, one block at a time.
        drive_point();
        for (int i = 0; i < 10; i++) begin
            send_block(vecs[i].in, vecs[i].tag, waited);
            wait_out($sformatf("vec%0d_wait", i));
            check($sformatf("vec%0d_data", i), OUT, vecs[i].exp);
            check($sformatf("vec%0d_tag", i), 128'(OUT_TAG), 128'(vecs[i].tag));
            drive_point();
        end

        // Every byte value once, back to back, scored by the monitor.
        base = n_out;
        for (int j = 0; j < 16; j++) begin
            for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(16 * j + k);
            send_block(d, 4'(j), waited);
        end
        wait_outputs(base, 16, "sweep_drain");
        check("sweep_count", 128'(n_out - base), 128'(16));
        drive_point();

        // Eight back-to-back blocks with downstream always ready.
        repeat (3) drive_point();
        run_max = 0;
        base    = n_out;
        for (int i = 0; i < 8; i++) begin
            send_block(rand_block(), 4'(i), waited);
            check("stream_no_wait", 128'(waited), 128'(0));
        end
        wait_outputs(base, 8, "stream_drain");
        check("stream_count", 128'(n_out - base), 128'(8));
        check("stream_consecutive", 128'(run_max), 128'(8));
        drive_point();

        // Six blocks under randomly toggling OUT_READY with two 5-cycle stall stretches.
        base = n_out;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_block(rand_block(), 4'(8 + i), waited);
                wait_outputs(base, 6, "bp_drain");
                done = 1'b1;
            end
            begin
                for (int cyc = 0; cyc < 400 && !done; cyc++) begin
                    drive_point();
                    if ((cyc >= 2 && cyc <= 6) || (cyc >= 12 && cyc <= 16)) OUT_READY = 1'b0;
                    else OUT_READY = 1'($urandom_range(0, 1));
                end
                OUT_READY = 1'b1;
            end
        join
        check("bp_count", 128'(n_out - base), 128'(6));
        drive_point();

        // Fill both stages with downstream stalled, then reset.
        OUT_READY = 1'b0;
        send_block(rand_block(), 4'h1, waited);
        send_block(rand_block(), 4'h2, waited);
        @(negedge CLK);
        check("fill_out_valid", 128'(OUT_VALID), 128'(1));
        check("fill_in_ready", 128'(IN_READY), 128'(0));
        drive_point();
        RST_N = 1'b0;
        drive_point();
        RST_N = 1'b1;
        @(negedge CLK);
        check("midrst_out_valid", 128'(OUT_VALID), 128'(0));
        check("midrst_out", OUT, 128'h0);
        check("midrst_in_ready", 128'(IN_READY), 128'(1));
        drive_point();
        OUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check("midrst_no_stale", 128'(OUT_VALID), 128'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/inv_shift_sub_stage.md
Name: inv_shift_sub_stage

Overview:
Decryption-round stage that consumes the 128-bit state produced by the inverse MixColumns stage. It applies InvShiftRows and then InvSubBytes. InvShiftRows is pure byte routing. InvSubBytes uses 16 synchronous inverse-S-box lookups, each with 1-cycle read latency and the same CLK / Read_Enable / Read_Address / Read_Data interface as the GF multiply tables. A 2-stage valid/ready pipeline with global stall handles backpressure from the AddRoundKey stage downstream, and a sideband tag carries the round/block identifier alongside the data.

Parameters:
TAG_W, 4, width of sideband tag (round number / block id) carried with the data; must be >= 1

Ports:
CLK  input  1  clock; all state updates on rising edge
RST_N  input  1  synchronous reset, active-low; sampled on rising CLK edge
IN_VALID  input  1  IN/IN_TAG valid this cycle
IN_READY  output  1  stage accepts IN this cycle
IN  input  [0:127]  state from inverse MixColumns; byte k = IN[8k:8k+7]; column c = bytes 4c..4c+3; row r = byte index within column
IN_TAG  input  TAG_W  sideband, travels with IN
OUT_VALID  output  1  OUT/OUT_TAG valid
OUT_READY  input  1  downstream accepts OUT this cycle
OUT  output  [0:127]  InvSubBytes(InvShiftRows(IN)), same byte/bit ordering as IN
OUT_TAG  output  TAG_W  tag of the block on OUT

Behaviour:
- Reset (RST_N=0 at a rising edge): clear OUT_VALID, the stage-1 valid v1 and OUT_TAG. Set OUT to 128'h0. S-box ROM output registers are not reset; their contents are qualified by v1.
- Reset mid-operation discards all in-flight blocks, with no partial output. IN_READY=1 in the first cycle after reset is released.
- Advance enable: en = ~OUT_VALID | OUT_READY.
- IN_READY = en (combinational; no dependency on IN_VALID). A transfer occurs when IN_VALID & IN_READY.
- InvShiftRows (combinational, before the ROMs): shifted byte (4c+r) = IN byte (4*((c-r) mod 4) + r) for r,c in 0..3. Row 0 is unchanged; row r rotates right by r columns.
- Stage 1: 16 inverse-S-box ROMs, address = shifted byte, Read_Enable = en.
  - When en=1: ROM data register loads; v1 <= IN_VALID; tag1 <= IN_TAG.
  - When en=0: ROMs, v1 and tag1 hold.
- Stage 2: when en=1: OUT <= ROM data; OUT_TAG <= tag1; OUT_VALID <= v1. When en=0: all stage-2 outputs hold.
- Latency is 2 cycles from accepted IN to OUT_VALID, with OUT_READY held high. Throughput is 1 block/cycle.
- Backpressure: while OUT_VALID=1 and OUT_READY=0, OUT, OUT_TAG and OUT_VALID must stay stable. IN_READY=0 in that case, and the stage-1 contents are held.
  - No block is dropped or duplicated; at most 2 blocks are in flight.
- Bubbles: if OUT_VALID=0, the stage advances regardless of OUT_READY. An empty stage 2 is filled even while downstream is stalled.
- Simultaneous events: on a cycle where the output is consumed and a new input is accepted, both happen; the pipeline shifts by one.
- Inverse S-box contents follow FIPS-197 InvSbox exactly (e.g. 00->52, 01->09, 63->00, 7c->01, ff->7d).
- Default Read_Enable behaviour of the table matches the existing lookup tables: the registered output updates only when Read_Enable=1.

Test Plan:
1. Reset, then IN=128'h0, IN_TAG=4'h3, IN_VALID=1 for one cycle, OUT_READY=1 -> exactly 2 cycles later OUT_VALID=1 for one cycle, OUT=16 bytes of 52, OUT_TAG=3.
2. IN bytes 00,01,...,0f (IN=128'h000102030405060708090a0b0c0d0e0f) -> OUT[0:31]=32'h52f3a338, OUT[32:63]=32'h3009d79e; all 16 bytes checked against a reference model, confirming the row-rotation direction.
3. Stream 8 back-to-back distinct blocks with tags 0..7 and OUT_READY=1 -> 8 consecutive OUT_VALID cycles, in order, with matching tags and IN_READY constantly 1.
4. Stream 6 blocks while OUT_READY toggles pseudo-randomly (including 5-cycle low stretches) -> OUT/OUT_TAG stable whenever OUT_VALID & ~OUT_READY; IN_READY=0 exactly when OUT_VALID & ~OUT_READY; all 6 blocks delivered once, in order.
5. Fill the pipeline (2 blocks in flight, OUT_READY=0), then assert RST_N=0 for one cycle -> next cycle OUT_VALID=0, OUT=0, IN_READY=1; no stale block appears afterwards.
6. IN_VALID=0 with OUT_READY=0 for 10 cycles after reset -> OUT_VALID stays 0 and IN_READY stays 1; IN contents are ignored (randomised) and produce no output.
